countdown_display_ctrl: RTL and testbench
=========================================

Name: countdown_display_ctrl

Overview:
- Sequences the content of the 4-digit multiplexed 7-segment display: a 3-digit BCD countdown timer (display[11:0]) plus an error counter digit (error_count[3:0]).
- Sits between the game/control logic (start, pause, error strobes) and the digit scan/decode driver. Owns all timing of what is shown.
- Produces status flags (busy, done, fail) for the upper-level FSM.

Parameters:
- CLK_DIV, 50000000: CLK cycles per countdown step (1 s at 50 MHz).
- MAX_ERR, 9: error count at which the run aborts. Legal range 1..9.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous reset, active-high.
- start  input  1  load preset and (re)start countdown; sampled each cycle.
- pause  input  1  level; while high in RUN the countdown freezes.
- err_in  input  1  error strobe; each rising edge counts one error.
- preset  input  12  BCD start value {hundreds, tens, ones}.
- display  output  12  BCD timer value {hundreds, tens, ones} to the display driver.
- error_count  output  4  binary 0..9 error count to the display driver.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE (timer reached 000).
- fail  output  1  high in FAIL (error_count reached MAX_ERR).

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST). RST has priority over all inputs, including mid-countdown.
- Reset values:
  - display = 12'h000, error_count = 0, busy = 0, done = 0, fail = 0.
  - state = IDLE, tick counter = 0, err_in edge register = 0.
- States: IDLE, RUN, PAUSE, DONE, FAIL. Registered outputs are decoded from the state and registers.
- Priority per cycle: RST > start > error abort > countdown step > pause.
- start (any state):
  - Next edge: display = clamped preset, error_count = 0, tick counter = 0.
  - state = RUN; if the clamped preset is 000, state = DONE instead.
  - Clamping: any preset nibble > 9 loads as 9 (e.g. preset 12'h1A3 loads 0x193).
  - start held high keeps reloading every cycle; counting begins after start drops.
- RUN:
  - Tick counter increments each cycle and wraps at CLK_DIV-1.
  - On the wrap cycle, display decrements by 1 in BCD with borrow (e.g. 0x100 -> 0x099, 0x010 -> 0x009).
  - The first step occurs CLK_DIV cycles after RUN entry.
  - If the decrement yields 000, state = DONE on the same edge.
- PAUSE:
  - Entered from RUN when pause = 1 on a non-wrap cycle.
  - Tick counter and display are frozen; return to RUN on the first cycle pause = 0, resuming from the held tick count.
  - A wrap cycle coinciding with a pause assertion still performs the step.
- Errors:
  - err_in is registered; a rising edge (previous 0, current 1) in RUN or PAUSE increments error_count.
  - Edges in IDLE/DONE/FAIL are ignored.
  - When error_count reaches MAX_ERR, state = FAIL on the same edge. display holds its value and error_count holds at MAX_ERR; no overflow.
  - An error edge and a countdown step in the same cycle both take effect. If both terminal conditions occur together, FAIL wins.
- DONE/FAIL:
  - All values are held; done/fail stay high until start or RST.
  - pause and err_in have no effect.
- IDLE: outputs hold their reset values until start.

Test Plan:
- Basic run (CLK_DIV=4): RST, then start pulse with preset 0x003 -> display 0x003 after 1 cycle; steps to 0x002, 0x001, 0x000 at 4-cycle intervals; done=1 and busy=0 in the same cycle display shows 0x000.
- BCD borrow and clamp (CLK_DIV=4): preset 0x100 -> after one step display = 0x099. Separately, preset 0x1AF loads 0x199.
- Pause (CLK_DIV=4): preset 0x005, pause high for 10 cycles after the first step -> display holds 0x004 for those 10 cycles and resumes; total time to 0x000 is extended by exactly 10 cycles.
- Errors/fail (MAX_ERR=3): err_in held high 5 cycles counts 1, not 5. Three separate pulses -> error_count = 3, fail = 1, display frozen. Further pulses leave error_count = 3.
- Simultaneous events:
  - Error edge on the same cycle as the step to 000 with error_count = MAX_ERR-1 -> fail = 1, done = 0.
  - start mid-RUN with preset 0x020 -> reloads 0x020 and clears error_count.
- Reset mid-operation: RST asserted in RUN at display 0x042 with error_count 2 -> next edge all outputs 0, state IDLE. err_in held high across RST deassert is not counted.

Source files
------------

// File: rtl/countdown_display_ctrl.sv
// Content sequencer for the 4-digit 7-segment display: a 3-digit BCD countdown timer
// plus an error digit, with busy/done/fail status for the supervising FSM.
module countdown_display_ctrl #(
    parameter int unsigned CLK_DIV = 50000000,
    parameter int unsigned MAX_ERR = 9
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        pause,
    input  logic        err_in,
    input  logic [11:0] preset,
    output logic [11:0] display,
    output logic [3:0]  error_count,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    localparam int unsigned    TickW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
    localparam logic [3:0]     ErrMax   = 4'(MAX_ERR);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StPause,
        StDone,
        StFail
    } state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [11:0]      disp_q, disp_d;
    logic [3:0]       err_cnt_q, err_cnt_d;
    logic             err_q;

    logic [11:0] preset_clamped;
    logic        active;
    logic        wrap;
    logic        advance;
    logic        err_edge;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4]  = 4'd9;
                r[11:8] = v[11:8] - 4'd1;
            end
        end
        return r;
    endfunction

    assign preset_clamped = {clamp_digit(preset[11:8]), clamp_digit(preset[7:4]),
                             clamp_digit(preset[3:0])};
    assign active   = (state_q == StRun) || (state_q == StPause);
    assign wrap     = (tick_q == TickLast);
    // PAUSE only ever holds a non-wrap count, so a due step is never deferred by pause.
    assign advance  = !pause || wrap;
    assign err_edge = err_in & ~err_q;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        disp_d    = disp_q;
        err_cnt_d = err_cnt_q;

        if (start) begin
            disp_d    = preset_clamped;
            err_cnt_d = 4'd0;
            tick_d    = '0;
            state_d   = (preset_clamped == 12'h000) ? StDone : StRun;
        end else if (active) begin
            if (advance) begin
                if (wrap) begin
                    tick_d = '0;
                    disp_d = bcd_dec(disp_q);
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            if (err_edge) begin
                err_cnt_d = err_cnt_q + 4'd1;
            end
            // Abort outranks completion when both land on the same edge.
            if (err_cnt_d == ErrMax) begin
                state_d = StFail;
            end else if (disp_d == 12'h000) begin
                state_d = StDone;
            end else begin
                state_d = advance ? StRun : StPause;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            disp_q    <= 12'h000;
            err_cnt_q <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            disp_q    <= disp_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_in;
        end
    end

    assign display     = disp_q;
    assign error_count = err_cnt_q;
    assign busy        = active;
    assign done        = (state_q == StDone);
    assign fail        = (state_q == StFail);

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// Directed plus randomized bench for countdown_display_ctrl, checked every cycle against
// a decimal-valued behavioural model of the timer and error counter.
module tb_countdown_display_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned MAX_ERR = 3;

    localparam int MIdle = 0;
    localparam int MRun  = 1;
    localparam int MDone = 2;
    localparam int MFail = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        err_in = 1'b0;
    logic [11:0] preset = 12'h000;
    logic [11:0] display;
    logic [3:0]  error_count;
    logic        busy;
    logic        done;
    logic        fail;

    int checks = 0;
    int failures = 0;

    // Model state: remaining time as a plain integer, ticks elapsed in the current second.
    int m_val = 0;
    int m_err = 0;
    int m_tick = 0;
    int m_mode = MIdle;
    bit m_prev = 1'b0;

    countdown_display_ctrl #(
        .CLK_DIV(CLK_DIV),
        .MAX_ERR(MAX_ERR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .pause      (pause),
        .err_in     (err_in),
        .preset     (preset),
        .display    (display),
        .error_count(error_count),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
    );

    always #5 CLK = ~CLK;

    function automatic int digit_val(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit edge_seen;
        if (RST) begin
            m_val  = 0;
            m_err  = 0;
            m_tick = 0;
            m_mode = MIdle;
            m_prev = 1'b0;
        end else begin
            edge_seen = err_in && !m_prev;
            m_prev    = err_in;
            if (start) begin
                m_val  = digit_val(preset[11:8]) * 100 + digit_val(preset[7:4]) * 10 +
                         digit_val(preset[3:0]);
                m_err  = 0;
                m_tick = 0;
                m_mode = (m_val == 0) ? MDone : MRun;
            end else if (m_mode == MRun) begin
                if (m_tick == CLK_DIV - 1) begin
                    m_tick = 0;
                    m_val  = m_val - 1;
                end else if (!pause) begin
                    m_tick = m_tick + 1;
                end
                if (edge_seen) m_err = m_err + 1;
                if (m_err == MAX_ERR) m_mode = MFail;
                else if (m_val == 0) m_mode = MDone;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        check("cyc_display", {4'h0, display}, {4'h0, to_bcd(m_val)});
        check("cyc_errcnt", {12'h0, error_count}, 16'(m_err));
        check("cyc_busy", {15'h0, busy}, {15'h0, m_mode == MRun});
        check("cyc_done", {15'h0, done}, {15'h0, m_mode == MDone});
        check("cyc_fail", {15'h0, fail}, {15'h0, m_mode == MFail});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_start(input logic [11:0] p);
        preset = p;
        start  = 1'b1;
        cycle();
        start  = 1'b0;
    endtask

    task automatic err_pulse();
        err_in = 1'b1;
        cycle();
        err_in = 1'b0;
        cycle();
    endtask

    initial begin
        int n;

        // Reset
        cycles(2);
        check("rst_display", {4'h0, display}, 16'h0000);
        check("rst_flags", {13'h0, busy, done, fail}, 16'h0000);
        RST = 1'b0;
        cycles(2);
        check("idle_hold", {4'h0, display}, 16'h0000);

        // Basic run
        do_start(12'h003);
        check("basic_load", {4'h0, display}, 16'h0003);
        cycles(4);
        check("basic_step1", {4'h0, display}, 16'h0002);
        cycles(4);
        check("basic_step2", {4'h0, display}, 16'h0001);
        cycles(4);
        check("basic_zero", {4'h0, display}, 16'h0000);
        check("basic_done", {14'h0, done, busy}, 16'h0002);
        cycles(3);
        check("done_hold", {15'h0, done}, 16'h0001);

        // BCD borrow and clamp
        do_start(12'h100);
        cycles(4);
        check("borrow", {4'h0, display}, 16'h0099);
        do_start(12'h1AF);
        check("clamp", {4'h0, display}, 16'h0199);
        do_start(12'h0F0);
        check("clamp_tens", {4'h0, display}, 16'h0090);

        // Pause extends the run by exactly the paused cycles
        do_start(12'h005);
        cycles(4);
        check("pause_pre", {4'h0, display}, 16'h0004);
        n = 0;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n++;
            check("pause_hold", {4'h0, display}, 16'h0004);
        end
        pause = 1'b0;
        while (!done && n < 100) begin
            cycle();
            n++;
        end
        check("pause_total", 16'(n), 16'd26);

        // Errors: held level counts once, abort at MAX_ERR, saturation
        do_start(12'h500);
        err_in = 1'b1;
        cycles(5);
        err_in = 1'b0;
        cycle();
        check("err_level", {12'h0, error_count}, 16'd1);
        err_pulse();
        err_pulse();
        check("err_fail", {12'h0, error_count, 1'b0, busy, done, fail}, 16'h0031);
        err_pulse();
        err_pulse();
        cycles(6);
        check("err_sat", {12'h0, error_count}, 16'd3);
        check("err_fail_hold", {15'h0, fail}, 16'h0001);

        // Error abort on the same edge as the final step
        do_start(12'h002);
        err_in = 1'b1; cycle();
        err_in = 1'b0; cycle();
        err_in = 1'b1; cycle();
        err_in = 1'b0; cycles(4);
        err_in = 1'b1; cycle();
        err_in = 1'b0;
        check("sim_fail", {14'h0, done, fail}, 16'h0001);
        check("sim_err", {12'h0, error_count}, 16'd3);

        // start during RUN reloads and clears errors
        do_start(12'h050);
        err_pulse();
        cycles(2);
        do_start(12'h020);
        check("restart_disp", {4'h0, display}, 16'h0020);
        check("restart_err", {12'h0, error_count}, 16'd0);
        check("restart_busy", {15'h0, busy}, 16'h0001);
        do_start(12'h000);
        check("zero_preset", {14'h0, busy, done}, 16'h0001);

        // Reset mid-run, err_in held high across deassert
        do_start(12'h042);
        err_in = 1'b1; cycle();
        err_in = 1'b0; cycle();
        err_in = 1'b1; cycle();
        check("rstmid_pre", {error_count, display}, 16'h2042);
        RST = 1'b1;
        cycle();
        check("rstmid_out", {error_count, display}, 16'h0000);
        check("rstmid_flags", {13'h0, busy, done, fail}, 16'h0000);
        RST = 1'b0;
        cycle();
        check("rstmid_idle", {11'h0, error_count, busy}, 16'h0000);
        do_start(12'h005);
        cycles(3);
        check("rstmid_noedge", {12'h0, error_count}, 16'd0);
        err_in = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RST    = ($urandom_range(0, 399) == 0);
            start  = ($urandom_range(0, 39) == 0);
            pause  = ($urandom_range(0, 3) == 0);
            err_in = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) preset = 12'($urandom_range(0, 4095));
            else preset = {8'h00, 4'($urandom_range(0, 15))};
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
